// File: rtl/instr_fetch_rx.sv
// instr_fetch_rx: credit-based instruction fetch with tag pipe and in-order skid FIFO
module instr_fetch_rx #(
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 2,
    parameter int AW      = 14
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pc_valid,
    input  logic [31:0]   pc,
    output logic          pc_ready,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          flush,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          instr_misalign,
    input  logic          instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(DEPTH + MEM_LAT + 1);

    logic          w_acc;
    logic          w_cap_v;
    logic [31:0]   w_cap_pc;
    logic          w_push;
    logic          w_pop;
    logic [SW-1:0] w_used;

    logic [OW-1:0] r_outst;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic          r_mis   [DEPTH];

    // A slot is reserved for every read in flight, so a capture always finds room.
    assign w_used         = SW'(r_outst) + SW'(r_count);
    assign pc_ready       = rstn && !flush && (w_used < SW'(DEPTH));
    assign w_acc          = pc_valid && pc_ready;
    assign imem_req       = w_acc;
    assign imem_addr      = pc[AW+1:2];
    assign w_push         = w_cap_v && !flush;
    assign w_pop          = instr_valid && instr_ready && !flush;
    assign instr_valid    = r_count != '0;
    assign instr          = r_instr[r_rptr];
    assign instr_pc       = r_pc[r_rptr];
    assign instr_misalign = r_mis[r_rptr];

    // Read data is valid in the cycle MEM_LAT-1 after the request; the tag
    // pipe delays the PC so it lines up with its returning word.
    if (MEM_LAT == 1) begin : g_direct
        assign w_cap_v  = w_acc;
        assign w_cap_pc = pc;
    end else begin : g_pipe
        logic        r_tag_v  [MEM_LAT-1];
        logic [31:0] r_tag_pc [MEM_LAT-1];
        // Tag shift register; flush kills every in-flight tag.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < MEM_LAT - 1; i++) begin
                    r_tag_v[i]  <= 1'b0;
                    r_tag_pc[i] <= '0;
                end
            end else begin
                r_tag_v[0]  <= w_acc && !flush;
                r_tag_pc[0] <= pc;
                for (int i = 1; i < MEM_LAT - 1; i++) begin
                    r_tag_v[i]  <= r_tag_v[i-1] && !flush;
                    r_tag_pc[i] <= r_tag_pc[i-1];
                end
            end
        end
        assign w_cap_v  = r_tag_v[MEM_LAT-2];
        assign w_cap_pc = r_tag_pc[MEM_LAT-2];
    end

    // Outstanding-read counter: up on accept, down on capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_outst <= '0;
        else
            r_outst <= flush ? '0 : r_outst + OW'(w_acc) - OW'(w_cap_v);
    end

    // FIFO storage and pointers; flush empties it and ignores any pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
                r_mis[i]   <= 1'b0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wptr] <= imem_rdata;
                r_pc[r_wptr]    <= w_cap_pc;
                r_mis[r_wptr]   <= |w_cap_pc[1:0];
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule
